// File: rtl/fetch_pkg.sv
// Shared widths, reset address and fetch-state encoding for the instruction fetch stage.
package fetch_pkg;

  localparam int INS_W_DEFAULT    = 25;
  localparam int PC_W_DEFAULT     = 20;
  localparam int RESET_PC_DEFAULT = 0;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry buffer that keeps the in-flight fetch word while decode is stalled.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int W = INS_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         full,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      data <= din;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// PC, sequential fetch, branch redirect and IF/ID register with a skid buffer for decode stalls.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int INS_W    = INS_W_DEFAULT,
  parameter int PC_W     = PC_W_DEFAULT,
  parameter int RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  input  logic             branch,
  input  logic             zero,
  input  logic [INS_W-1:0] ext,
  input  logic [PC_W-1:0]  br_pc,
  input  logic             stall,
  output logic             id_valid,
  output logic [INS_W-1:0] id_ins,
  output logic [PC_W-1:0]  id_pc
);

  fetch_state_e     state, state_next;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  f_pc;
  logic             f_valid;
  logic             taken;
  logic             advance;
  logic             skid_load;
  logic             skid_clear;
  logic             skid_full;
  logic [INS_W-1:0] skid_ins;
  logic [PC_W-1:0]  target;
  logic             unused_ext_hi;

  assign taken     = branch & zero;
  assign imem_addr = pc;

  // Offset is in words; truncating ext to PC_W keeps backward offsets correct.
  assign target        = br_pc + PC_W'(1) + ext[PC_W-1:0];
  assign unused_ext_hi = ^ext[INS_W-1:PC_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    state_next = (taken || stall) ? FILL : RUN;
      RUN:     state_next = taken ? FILL : (stall ? HOLD : RUN);
      HOLD:    state_next = taken ? FILL : (stall ? HOLD : RUN);
      default: state_next = FILL;
    endcase
  end

  // The word in flight is captured only on the first stall cycle; later cycles return ins[pc].
  always_comb begin
    f_valid    = (state != FILL);
    advance    = !taken && !stall;
    skid_load  = !taken && stall && (state == RUN);
    skid_clear = taken || advance;
  end

  fetch_skid_buf #(.W(INS_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (imem_rdata),
    .full  (skid_full),
    .data  (skid_ins)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= PC_W'(RESET_PC);
      f_pc     <= '0;
      id_valid <= 1'b0;
      id_ins   <= '0;
      id_pc    <= '0;
    end else if (taken) begin
      pc       <= target;
      id_valid <= 1'b0;
    end else if (advance) begin
      id_valid <= f_valid;
      id_ins   <= skid_full ? skid_ins : imem_rdata;
      id_pc    <= f_pc;
      f_pc     <= pc;
      pc       <= pc + PC_W'(1);
    end
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Program-counter and fetch stage that drives the instruction memory and delivers instructions to decode through an IF/ID register. The memory is word-addressed with a one-cycle synchronous read and no enable. The block holds the PC, issues sequential fetches and redirects on a taken branch reported by execute. A one-entry skid buffer preserves the in-flight instruction across decode stalls.

## Interface
- INS_W, 25, instruction and extended-immediate width
- PC_W, 20, PC and memory address width (word index)
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- imem_addr  out  PC_W  fetch address; equals the pc register
- imem_rdata  in  INS_W  memory data for the address presented in the previous cycle
- branch  in  1  execute: instruction is a branch
- zero  in  1  execute: ALU zero flag
- ext  in  INS_W  execute: sign-extended branch offset, in words
- br_pc  in  PC_W  execute: PC of the branch instruction
- stall  in  1  decode hazard; hold IF/ID and the fetch pipeline
- id_valid  out  1  IF/ID holds a live instruction
- id_ins  out  INS_W  IF/ID instruction
- id_pc  out  PC_W  IF/ID instruction address

## Operation
- Internal state:
  - pc
  - f_pc and f_valid: imem_rdata this cycle belongs to f_pc
  - skid_ins and skid_full
  - IF/ID registers
- taken = branch & zero. Priority per cycle: taken > stall > advance.
- Taken:
  - pc <= br_pc + 1 + ext[PC_W-1:0], modulo 2^PC_W.
  - f_valid <= 0, skid_full <= 0, id_valid <= 0, which kills both wrong-path instructions.
  - id_ins and id_pc hold.
- Stall, not taken:
  - IF/ID, pc, f_pc and f_valid hold.
  - If f_valid & !skid_full: skid_ins <= imem_rdata, skid_full <= 1. This is needed because the held address returns ins[pc], not ins[f_pc], from the next cycle.
  - If f_valid = 0, nothing is captured.
- Advance:
  - id_valid <= f_valid.
  - id_ins <= skid_full ? skid_ins : imem_rdata.
  - id_pc <= f_pc.
  - f_pc <= pc, f_valid <= 1, pc <= pc + 1 (wraps 2^PC_W-1 -> 0), skid_full <= 0.
- FSM view (derived from f_valid and skid_full; may be an explicit enum):
  - FILL (f_valid=0): after reset or a taken branch. Advance -> RUN. Stall -> FILL. Taken -> FILL.
  - RUN (f_valid=1, skid empty): stall -> HOLD. Advance -> RUN. Taken -> FILL.
  - HOLD (skid_full=1): stall -> HOLD with no recapture. Advance -> RUN, consuming the skid. Taken -> FILL, discarding the skid.
- ext wider than PC_W: upper bits are ignored; two's-complement truncation gives the correct backward offset.

## Timing
- Reset values:
  - pc = RESET_PC, imem_addr = RESET_PC
  - f_pc = 0, f_valid = 0, skid_full = 0, skid_ins = 0
  - id_valid = 0, id_ins = 0, id_pc = 0
- Reset asserted mid-operation clears everything immediately, including any skid content, without waiting for the clock edge.
- First instruction latency: with no stall, id_valid first rises at the second rising edge after reset deasserts, carrying id_pc = RESET_PC.
- Steady state: one instruction per cycle into IF/ID.
- Taken branch costs two bubbles: id_valid = 0 for two cycles, then id_pc = target.
- branch, zero, ext and br_pc are sampled only at the clock edge; the block has no combinational path from them to any output.

## Structure
- Package fetch_pkg:
  - INS_W and PC_W defaults, RESET_PC
  - fetch state enum {FILL, RUN, HOLD}
- Sub-module fetch_skid_buf: one-entry INS_W buffer with load, clear, full and data.
- Top level holds the pc, fetch-tracking and IF/ID registers, target adder and priority logic.

## Test plan
- Reset, memory word i = 0x100+i, no stall:
  - id_valid first high at edge 2 with id_pc = 0, id_ins = 0x100.
  - Then id_pc = 1, 2, 3… on consecutive cycles.
- Stall for 3 cycles while id_pc = 4: IF/ID holds 4. On release, id_pc = 5 with id_ins = 0x105 (from the skid), then 6 = 0x106; no duplicate or skipped instruction.
- Taken branch, br_pc = 6, ext = 3: two id_valid = 0 cycles, then id_pc = 10, id_ins = 0x10A.
- Backward branch:
  - br_pc = 8, ext = 25'h1FFFFFC (-4) -> next valid id_pc = 5.
  - br_pc = 0, ext = -2 -> id_pc = 2^20-1.
- Simultaneous taken and stall in HOLD: skid discarded, redirect honoured, next valid id_pc = target.
- Reset asserted mid-stall with the skid full: all outputs return to reset values without a clock edge; the sequence then restarts from RESET_PC.
